// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals shared by the port arbiter.
// master: the arbiter's view. slave: the view of the pipeline plus memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [1:0]  d_size;
  logic        d_sign;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_error;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_sign,
           mem_ack, mem_rdata,
    output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_error, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, d_sign,
           mem_ack, mem_rdata,
    input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_error, d_stall,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the MEM stage,
// with byte-lane steering for stores, load extension, starvation guard and timeout.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                reset,
  mem_port_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, D_ERR} state_t;

  state_t        state_q;
  logic [SW-1:0] streak_q;
  logic [TW-1:0] tmo_q;
  logic [1:0]    size_q;
  logic          sign_q;
  logic [1:0]    off_q;
  logic [31:0]   if_rdata_q;
  logic          if_valid_q;
  logic [31:0]   d_rdata_q;
  logic          d_valid_q;
  logic          d_error_q;
  logic          mem_req_q;
  logic          mem_we_q;
  logic [31:0]   mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [3:0]    mem_be_q;

  logic          streak_full;
  logic          grant_d;
  logic          grant_i;
  logic          d_bad;
  logic [TW-1:0] tmo_d;
  logic          tmo_hit;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [31:0]   load_d;
  logic [7:0]    rd_lane [4];
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic          unused_bits;

  // Fetch only overrides a pending data request once data has used up its streak.
  assign streak_full = (streak_q == SW'(STARVE_LIMIT));
  assign grant_d     = bus.d_req && !(streak_full && bus.if_req);
  assign grant_i     = bus.if_req && !grant_d;
  assign d_bad       = (bus.d_size == 2'b11) ||
                       (bus.d_size == 2'b01 && bus.d_addr[0]) ||
                       (bus.d_size == 2'b10 && bus.d_addr[1:0] != 2'b00);
  assign tmo_d       = tmo_q + TW'(1);
  assign tmo_hit     = (tmo_d == TW'(TIMEOUT_CYCLES));
  assign unused_bits = ^bus.if_addr[1:0];

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.d_wdata;
    case (bus.d_size)
      2'b00: begin
        be_d    = 4'b0001 << bus.d_addr[1:0];
        wdata_d = {4{bus.d_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << bus.d_addr[1:0];
        wdata_d = {2{bus.d_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = bus.mem_rdata[8*gi +: 8];
  end

  assign byte_sel = rd_lane[off_q];
  assign half_sel = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    load_d = bus.mem_rdata;
    case (size_q)
      2'b00:   load_d = {{24{sign_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_d = {{16{sign_q & half_sel[15]}}, half_sel};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      tmo_q       <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      off_q       <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_valid_q   <= 1'b0;
      d_error_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      d_error_q  <= 1'b0;
      if (!bus.if_req) streak_q <= '0;
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (grant_d) begin
            if (bus.if_req && !streak_full) streak_q <= streak_q + SW'(1);
            size_q <= bus.d_size;
            sign_q <= bus.d_sign;
            off_q  <= bus.d_addr[1:0];
            if (d_bad) begin
              state_q <= D_ERR;
            end else begin
              state_q     <= BUSY_D;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.d_we;
              mem_addr_q  <= {bus.d_addr[31:2], 2'b00};
              mem_be_q    <= bus.d_we ? be_d : 4'b1111;
              mem_wdata_q <= wdata_d;
            end
          end else if (grant_i) begin
            streak_q   <= '0;
            state_q    <= BUSY_I;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {bus.if_addr[31:2], 2'b00};
            mem_be_q   <= 4'b1111;
          end
        end
        BUSY_I: begin
          if (bus.mem_ack || tmo_hit) begin
            // A stuck fetch completes with a NOP so the pipeline keeps moving.
            if_rdata_q <= bus.mem_ack ? bus.mem_rdata : 32'h0000_0013;
            if_valid_q <= 1'b1;
            mem_req_q  <= 1'b0;
            state_q    <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        BUSY_D: begin
          if (bus.mem_ack) begin
            if (!mem_we_q) d_rdata_q <= load_d;
            d_valid_q <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else if (tmo_hit) begin
            d_rdata_q <= '0;
            d_valid_q <= 1'b1;
            d_error_q <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        D_ERR: begin
          d_rdata_q <= '0;
          d_valid_q <= 1'b1;
          d_error_q <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_stall  = bus.if_req && !if_valid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_valid   = d_valid_q;
  assign bus.d_error   = d_error_q;
  assign bus.d_stall   = bus.d_req && !d_valid_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, completion scoreboard,
// plus contention, timeout and mid-transaction reset sequences.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(
    .STARVE_LIMIT  (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        port_d;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] mword;
    logic        access;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        chk_rd;
    logic        e_err;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[13];
  logic        ack_en    = 1'b1;
  int          ack_lat   = 1;
  logic        force_ack = 1'b0;
  logic [31:0] mem_word  = '0;
  int          busy_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_check(input logic port_d, input logic [31:0] rdata, input logic err);
    exp_t e;
    $display("txn port=%s rdata=%h err=%b", port_d ? "D" : "I", rdata, err);
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_valid actual=%s required=none", port_d ? "D" : "I");
    end else begin
      e = sb.pop_front();
      chk("sb_port", 32'(port_d), 32'(e.port_d));
      if (e.chk_rd) chk("sb_rdata", rdata, e.rdata);
      if (e.port_d) chk("sb_error", 32'(err), 32'(e.err));
    end
  endtask

  // Memory model: acks after ack_lat busy cycles, force_ack injects stray acks.
  always @(posedge clk) begin
    #1;
    if (bus.mem_req) begin
      busy_cnt++;
      if (ack_en && busy_cnt >= ack_lat) begin
        bus.mem_ack = 1'b1;
        busy_cnt    = 0;
      end else begin
        bus.mem_ack = 1'b0;
      end
    end else begin
      busy_cnt    = 0;
      bus.mem_ack = force_ack;
    end
    bus.mem_rdata = mem_word;
  end

  always @(posedge clk) begin
    #1;
    if (bus.if_valid) sb_check(1'b0, bus.if_rdata, 1'b0);
    if (bus.d_valid)  sb_check(1'b1, bus.d_rdata, bus.d_error);
  end

  task automatic run_vec(input vec_t v, input int idx);
    logic seen = 1'b0;
    logic done = 1'b0;
    logic vld;
    mem_word = v.mword;
    sb.push_back('{v.is_d, v.e_rdata, v.chk_rd, v.e_err});
    if (v.is_d) begin
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
      bus.d_size  = v.size;
      bus.d_sign  = v.sign;
      bus.d_req   = 1'b1;
    end else begin
      bus.if_addr = v.addr;
      bus.if_req  = 1'b1;
    end
    for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 1)
        chk($sformatf("v%0d_stall", idx), 32'(v.is_d ? bus.d_stall : bus.if_stall), 32'(1));
      if (bus.mem_req && !seen) begin
        seen = 1'b1;
        chk($sformatf("v%0d_mem_addr", idx), bus.mem_addr, v.e_addr);
        chk($sformatf("v%0d_mem_be", idx), 32'(bus.mem_be), 32'(v.e_be));
        chk($sformatf("v%0d_mem_we", idx), 32'(bus.mem_we), 32'(v.we));
        if (v.we) chk($sformatf("v%0d_mem_wdata", idx), bus.mem_wdata, v.e_wdata);
      end
      vld = v.is_d ? bus.d_valid : bus.if_valid;
      if (vld) begin
        done = 1'b1;
        chk($sformatf("v%0d_latency", idx), 32'(cyc), 32'(2));
        chk($sformatf("v%0d_stall_off", idx), 32'(v.is_d ? bus.d_stall : bus.if_stall), 32'(0));
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
    end
    if (!done) begin
      chk($sformatf("v%0d_no_completion", idx), 32'(0), 32'(1));
      bus.if_req = 1'b0;
      bus.d_req  = 1'b0;
    end
    chk($sformatf("v%0d_mem_access", idx), 32'(seen), 32'(v.access));
    @(posedge clk);
    #1;
  endtask

  task automatic timeout_run(input logic is_d, input logic [31:0] addr);
    int   busy = 0;
    logic done = 1'b0;
    ack_en = 1'b0;
    sb.push_back('{is_d, is_d ? 32'h0 : 32'h0000_0013, 1'b1, is_d});
    if (is_d) begin
      bus.d_we   = 1'b0;
      bus.d_addr = addr;
      bus.d_size = 2'b10;
      bus.d_sign = 1'b0;
      bus.d_req  = 1'b1;
    end else begin
      bus.if_addr = addr;
      bus.if_req  = 1'b1;
    end
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req) busy++;
      if (is_d ? bus.d_valid : bus.if_valid) begin
        done = 1'b1;
        chk(is_d ? "tmo_d_busy" : "tmo_i_busy", 32'(busy), 32'(8));
        chk(is_d ? "tmo_d_mem_req" : "tmo_i_mem_req", 32'(bus.mem_req), 32'(0));
        bus.d_req  = 1'b0;
        bus.if_req = 1'b0;
      end
    end
    if (!done) begin
      chk("tmo_no_completion", 32'(0), 32'(1));
      bus.d_req  = 1'b0;
      bus.if_req = 1'b0;
    end
    ack_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_order[6];
    int   n;
    int   d_done;
    logic is_d;

    //            is_d we  addr          wdata         sz     sg  mword         acc  e_addr        e_be     e_wdata       e_rdata       chk  err
    vecs[0]  = '{1'b0, 1'b0, 32'h100, 32'h0,        2'b10, 1'b0, 32'h00A00093, 1'b1, 32'h100, 4'b1111, 32'h0,        32'h00A00093, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h203, 32'h0,        2'b00, 1'b1, 32'h80FFFFFF, 1'b1, 32'h200, 4'b1111, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'h203, 32'h0,        2'b00, 1'b0, 32'h80FFFFFF, 1'b1, 32'h200, 4'b1111, 32'h0,        32'h00000080, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 32'h012, 32'h0000BEEF, 2'b01, 1'b0, 32'h0,        1'b1, 32'h010, 4'b1100, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 32'h201, 32'h123456A5, 2'b00, 1'b0, 32'h0,        1'b1, 32'h200, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h040, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0,        1'b1, 32'h040, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h042, 32'h0,        2'b01, 1'b1, 32'h80017FFF, 1'b1, 32'h040, 4'b1111, 32'h0,        32'hFFFF8001, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h040, 32'h0,        2'b01, 1'b0, 32'h1234F00D, 1'b1, 32'h040, 4'b1111, 32'h0,        32'h0000F00D, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h044, 32'h0,        2'b10, 1'b1, 32'hCAFEF00D, 1'b1, 32'h044, 4'b1111, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h006, 32'h0,        2'b10, 1'b0, 32'h55555555, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h013, 32'h0,        2'b01, 1'b0, 32'h55555555, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 32'h020, 32'h0,        2'b11, 1'b0, 32'h55555555, 1'b0, 32'h0,   4'b0000, 32'h0,        32'h0,        1'b1, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 32'h200, 32'h0,        2'b00, 1'b1, 32'h0000007F, 1'b1, 32'h200, 4'b1111, 32'h0,        32'h0000007F, 1'b1, 1'b0};

    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_size  = 2'b10;
    bus.d_sign  = 1'b0;
    reset       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_mem_req", 32'(bus.mem_req), 32'(0));
    chk("rst_mem_we", 32'(bus.mem_we), 32'(0));
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_mem_be", 32'(bus.mem_be), 32'(0));
    chk("rst_valids", 32'({bus.if_valid, bus.d_valid, bus.d_error}), 32'(0));
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Contention: both ports held; expect data x4, then forced fetch, then data.
    mem_word = 32'h11112222;
    exp_order[0] = 1'b1; exp_order[1] = 1'b1; exp_order[2] = 1'b1;
    exp_order[3] = 1'b1; exp_order[4] = 1'b0; exp_order[5] = 1'b1;
    for (int i = 0; i < 6; i++) sb.push_back('{exp_order[i], 32'h11112222, 1'b1, 1'b0});
    bus.if_addr = 32'h300;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h040;
    bus.d_size  = 2'b10;
    bus.d_sign  = 1'b0;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    n      = 0;
    d_done = 0;
    for (int cyc = 1; cyc <= 60 && (bus.if_req || bus.d_req); cyc++) begin
      @(posedge clk);
      #1;
      if (bus.mem_req && n < 6) begin
        is_d = (bus.mem_addr == 32'h040);
        chk($sformatf("grant%0d_is_data", n), 32'(is_d), 32'(exp_order[n]));
        n++;
      end
      if (bus.if_req) begin
        if (bus.if_valid) begin
          chk("cont_if_stall_off", 32'(bus.if_stall), 32'(0));
          bus.if_req = 1'b0;
        end else begin
          chk("cont_if_stall", 32'(bus.if_stall), 32'(1));
        end
      end
      if (bus.d_valid) begin
        d_done++;
        if (d_done == 5) bus.d_req = 1'b0;
      end
    end
    chk("cont_grants", 32'(n), 32'(6));
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    timeout_run(1'b1, 32'h080);
    timeout_run(1'b0, 32'h104);

    // Reset while BUSY_D: no completion, and stray acks afterwards are ignored.
    ack_en      = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h084;
    bus.d_size  = 2'b10;
    bus.d_req   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstmid_busy", 32'(bus.mem_req), 32'(1));
    reset     = 1'b1;
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_mem_req", 32'(bus.mem_req), 32'(0));
    chk("rstmid_d_valid", 32'(bus.d_valid), 32'(0));
    reset     = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    force_ack = 1'b0;
    ack_en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("late_ack_mem_req", 32'(bus.mem_req), 32'(0));
      chk("late_ack_valid", 32'({bus.if_valid, bus.d_valid}), 32'(0));
    end

    chk("sb_empty", 32'(sb.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between instruction fetch (read-only) and the MEM stage (load/store).
- Grants one requester at a time, drives a word-addressed memory handshake and generates byte enables from the load/store size.
- Extracts and sign- or zero-extends load data.
- Drives per-port stall outputs consumed by the pipeline hazard logic.

Parameters:
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced.
- TIMEOUT_CYCLES, 64, busy cycles without mem_ack before the transaction is aborted with an error.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held until if_valid.
- if_addr  in  32  fetch byte address; word-aligned.
- if_rdata  out  32  fetched instruction word.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  if_req && !if_valid.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, LSB-aligned.
- d_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- d_sign  in  1  sign-extend load result.
- d_rdata  out  32  extended load data.
- d_valid  out  1  one-cycle completion pulse for data.
- d_error  out  1  qualifies d_valid: misaligned, illegal size or timeout.
- d_stall  out  1  d_req && !d_valid.
- mem_req  out  1  memory request, level.
- mem_we  out  1  write strobe.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wdata  out  32  store data replicated into the addressed lanes.
- mem_be  out  4  byte enables; 4'b1111 for reads.
- mem_ack  in  1  one-cycle completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  32  read word.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, D_ERR.
- Reset: state IDLE; all outputs 0, including mem_be and all data buses; streak counter and timeout counter 0.
- IDLE grant:
  - Data wins if d_req, unless streak == STARVE_LIMIT and if_req, in which case fetch wins.
  - Fetch wins if only if_req.
  - On grant, address, we, be, wdata, size, sign and offset are registered.
- IDLE transitions:
  - Fetch grant -> BUSY_I.
  - Legal data grant -> BUSY_D.
  - Misaligned or illegal data grant (half with addr[0]=1; word with addr[1:0]!=0; size 11) -> D_ERR. No memory access is made.
- BUSY_I/BUSY_D:
  - mem_req=1 with registered fields stable.
  - On mem_ack: mem_req=0 next cycle, return to IDLE, pulse the port's valid next cycle with registered data.
  - Earliest completion is 2 cycles after the request is first seen in IDLE (grant cycle, ack cycle, valid cycle).
  - Back-to-back: a new grant is possible in the cycle valid is pulsed.
- Timeout: the counter increments each busy cycle and clears on grant. When it reaches TIMEOUT_CYCLES with no ack, return to IDLE and pulse valid.
  - Data port: d_error=1, d_rdata=0.
  - Fetch port: if_rdata=32'h0000_0013 (NOP).
- D_ERR: one cycle, then d_valid=1, d_error=1, d_rdata=0; return to IDLE.
- Store lanes:
  - byte: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: be = 4'b0011 << addr[1:0], wdata = {2{wdata[15:0]}}.
  - word: be = 4'b1111.
- Load extraction: byte/half selected by the registered offset, then sign- or zero-extended per d_sign to 32 bits. Word is passed through.
- Streak counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant while if_req=1.
  - Clears on fetch grant or when if_req=0.
- Valid pulses last exactly one cycle. rdata holds its value until the next completion on that port.
- mem_ack in IDLE or D_ERR is ignored.
- Reset mid-transaction: IDLE next cycle, mem_req=0, no valid pulse; any late ack is ignored.
- Requester dropping req mid-transaction is illegal; the transaction completes regardless.

Test Plan:
- Fetch only: if_addr=0x100, mem_rdata=0x00A00093, ack at 1st busy cycle -> mem_addr=0x100, mem_be=1111, if_valid 2 cycles after req, if_rdata=0x00A00093.
- Signed byte load: d_addr=0x203, size=00, sign=1, mem_rdata=0x80FFFFFF -> mem_addr=0x200, d_rdata=0xFFFFFF80; with sign=0 -> 0x00000080.
- Half store: d_addr=0x12, wdata=0x0000BEEF -> mem_addr=0x10, mem_be=1100, mem_wdata=0xBEEFBEEF, mem_we=1.
- Contention, STARVE_LIMIT=4: if_req and d_req held continuously -> grant order D,D,D,D,I,D,...; if_stall high until fetch completes.
- Misaligned word: d_addr=0x6, size=10 -> mem_req never asserts; d_valid with d_error=1 two cycles after req.
- Timeout: mem_ack held 0 with TIMEOUT_CYCLES=8 -> mem_req drops after 8 busy cycles, d_valid with d_error=1; reset asserted during BUSY_D -> IDLE with mem_req=0 next cycle and no d_valid.
